// File: rtl/belfft_pkg.sv
// Shared widths, complex-sample type and Q1.15 rounding/saturation constants for the bel_fft datapath.
package belfft_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 6;

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Half-LSB of the output format, added before the truncating shift.
  function automatic int round_const(input int dw);
    return 1 << (dw - 2);
  endfunction

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/belfft_round_sat.sv
// Rounds one (2*DW+1)-bit product sum back to Q1.15 (round half up) and clamps it to the signed range.
module belfft_round_sat
  import belfft_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic signed [2*DW:0]   i_sum,
  output logic signed [DW-1:0]   o_res
);

  localparam int SW = 2*DW + 1;
  localparam logic signed [SW-1:0] RND  = SW'(round_const(DW));
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DW));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(DW));

  logic signed [SW-1:0] w_rnd;
  logic signed [SW-1:0] w_shr;

  assign w_rnd = i_sum + RND;
  assign w_shr = w_rnd >>> (DW - 1);

  always_comb begin
    o_res = w_shr[DW-1:0];
    if (w_shr > MAXV) begin
      o_res = MAXV[DW-1:0];
    end else if (w_shr < MINV) begin
      o_res = MINV[DW-1:0];
    end
  end

endmodule

// File: rtl/belfft_twiddle_mul.sv
// Complex sample x Q1.15 twiddle: ROM fetch, 4 products, round/saturate; 3 register stages, whole pipe stalls on !out_ready.
// Optional BELFFT_TWIDDLE_CONJ_EN adds in_inverse, selecting the conjugate twiddle per sample (IFFT).
module belfft_twiddle_mul
  import belfft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_re,
  input  logic [DATA_WIDTH-1:0]   in_im,
  input  logic [ADDR_WIDTH-1:0]   in_tw_idx,
`ifdef BELFFT_TWIDDLE_CONJ_EN
  input  logic                    in_inverse,
`endif
  output logic                    rom_clken,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  input  logic [2*DATA_WIDTH-1:0] rom_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_re,
  output logic [DATA_WIDTH-1:0]   out_im
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int SW = 2*DATA_WIDTH + 1;

  logic                         w_adv;
  logic                         r_v1, r_v2, r_v3;
  cplx_t                        r_d1;
  logic signed [DATA_WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic signed [PW-1:0]         r_ac, r_bd, r_ad, r_bc;
  logic signed [SW-1:0]         w_re_sum, w_im_sum;
  logic signed [DATA_WIDTH-1:0] w_re_rs, w_im_rs;
  logic [DATA_WIDTH-1:0]        r_re3, r_im3;
`ifdef BELFFT_TWIDDLE_CONJ_EN
  logic                         r_inv1, r_inv2;
`endif

  // ROM clock enable shares the stall so its output stays paired with r_d1.
  assign w_adv       = !r_v3 || out_ready;
  assign in_ready    = w_adv;
  assign rom_clken   = w_adv;
  assign rom_address = in_tw_idx;

  assign w_a = r_d1.re;
  assign w_b = r_d1.im;
  assign w_c = rom_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_d = rom_q[DATA_WIDTH-1:0];

  // The conjugate flips the sign of the d terms at the adder, so -(-1.0) never has to be represented.
  always_comb begin
    w_re_sum = SW'(r_ac) - SW'(r_bd);
    w_im_sum = SW'(r_ad) + SW'(r_bc);
`ifdef BELFFT_TWIDDLE_CONJ_EN
    if (r_inv2) begin
      w_re_sum = SW'(r_ac) + SW'(r_bd);
      w_im_sum = SW'(r_bc) - SW'(r_ad);
    end
`endif
  end

  belfft_round_sat #(.DW(DATA_WIDTH)) u_rs_re (
    .i_sum (w_re_sum),
    .o_res (w_re_rs)
  );

  belfft_round_sat #(.DW(DATA_WIDTH)) u_rs_im (
    .i_sum (w_im_sum),
    .o_res (w_im_rs)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_d1  <= '0;
      r_ac  <= '0;
      r_bd  <= '0;
      r_ad  <= '0;
      r_bc  <= '0;
      r_re3 <= '0;
      r_im3 <= '0;
`ifdef BELFFT_TWIDDLE_CONJ_EN
      r_inv1 <= 1'b0;
      r_inv2 <= 1'b0;
`endif
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_d1  <= {in_re, in_im};
      r_v2  <= r_v1;
      r_ac  <= PW'(w_a) * PW'(w_c);
      r_bd  <= PW'(w_b) * PW'(w_d);
      r_ad  <= PW'(w_a) * PW'(w_d);
      r_bc  <= PW'(w_b) * PW'(w_c);
      r_v3  <= r_v2;
      r_re3 <= w_re_rs;
      r_im3 <= w_im_rs;
`ifdef BELFFT_TWIDDLE_CONJ_EN
      r_inv1 <= in_inverse;
      r_inv2 <= r_inv1;
`endif
    end
  end

  assign out_valid = r_v3;
  assign out_re    = r_re3;
  assign out_im    = r_im3;

endmodule

// File: tb/tb_belfft_twiddle_mul.sv
// Scoreboard bench for belfft_twiddle_mul: driver pushes model results on accept, monitor pops on output handshake.
module tb_belfft_twiddle_mul;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_valid, in_ready, rom_clken, out_valid;
  logic [DW-1:0] in_re, in_im, out_re, out_im;
  logic [AW-1:0] in_tw_idx, rom_address;
  logic [2*DW-1:0] rom_q;
`ifdef BELFFT_TWIDDLE_CONJ_EN
  logic          in_inverse;
`endif

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t            exp_q[$];
  logic [2*DW-1:0] rom[64];
  int              n_tot = 0;
  int              n_bad = 0;
  int              cyc   = 0;
  int              rdy_mode = 0;

  belfft_twiddle_mul #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_tw_idx   (in_tw_idx),
`ifdef BELFFT_TWIDDLE_CONJ_EN
    .in_inverse  (in_inverse),
`endif
    .rom_clken   (rom_clken),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_re      (out_re),
    .out_im      (out_im)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (rom_clken) rom_q <= rom[rom_address];

  always @(negedge clock) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  function automatic logic [DW-1:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic bit rnd_inv();
`ifdef BELFFT_TWIDDLE_CONJ_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Exact integer arithmetic, then half-up rounding to Q1.15 and clamping.
  function automatic logic [DW-1:0] q15(input longint x);
    longint y;
    y = (x + 16384) >>> 15;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y[DW-1:0];
  endfunction

  function automatic exp_t model(input logic [DW-1:0] re, input logic [DW-1:0] im,
                                 input logic [AW-1:0] idx, input bit inv);
    longint a, b, c, d;
    logic [2*DW-1:0] w;
    exp_t e;
    w = rom[idx];
    a = longint'($signed(re));
    b = longint'($signed(im));
    c = longint'($signed(w[31:16]));
    d = longint'($signed(w[15:0]));
    if (inv) d = -d;
    e.re  = q15(a*c - b*d);
    e.im  = q15(a*d + b*c);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input logic [AW-1:0] idx, input bit inv, input bit lat);
    bit   acc;
    bit   first;
    int   guard;
    exp_t e;
    in_valid  = 1'b1;
    in_re     = re;
    in_im     = im;
    in_tw_idx = idx;
`ifdef BELFFT_TWIDDLE_CONJ_EN
    in_inverse = inv;
`endif
    acc = 1'b0;
    first = 1'b1;
    guard = 0;
    while (!acc && guard < 1000) begin
      #2;
      if (first) chk("rom_address", 32'(rom_address), 32'(idx));
      first = 1'b0;
      acc = in_ready;
      if (acc) begin
        e = model(re, im, idx, inv);
        e.cyc = cyc + 1;
        e.lat = lat;
        exp_q.push_back(e);
      end
      @(negedge clock);
      guard++;
    end
    if (!acc) begin
      n_tot++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, want accept", guard);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clock);
      g++;
    end
    n_tot++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d outputs pending, want 0", exp_q.size());
    end
  endtask

  initial begin : monitor
    bit            prev_stall;
    logic [DW-1:0] pre, pim;
    exp_t          e;
    prev_stall = 1'b0;
    pre = '0;
    pim = '0;
    forever begin
      @(negedge clock);
      #3;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_tot++;
          if (out_valid !== 1'b1 || out_re !== pre || out_im !== pim) begin
            n_bad++;
            $display("FAIL stall_hold: got v=%b %h/%h want v=1 %h/%h", out_valid, out_re, out_im, pre, pim);
          end
        end else if (out_valid === 1'b1 && exp_q.size() != 0 && exp_q[0].lat) begin
          n_tot++;
          if (cyc != exp_q[0].cyc + 2) begin
            n_bad++;
            $display("FAIL latency: got cycle %0d want %0d", cyc, exp_q[0].cyc + 2);
          end
        end
        if (out_valid === 1'b1 && out_ready) begin
          n_tot++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out: got %h/%h want no output", out_re, out_im);
          end else begin
            e = exp_q.pop_front();
            if (out_re !== e.re || out_im !== e.im) begin
              n_bad++;
              $display("FAIL product: got %h/%h want %h/%h", out_re, out_im, e.re, e.im);
            end
          end
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        pre = out_re;
        pim = out_im;
      end
    end
  end

  initial begin
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_tw_idx = '0;
`ifdef BELFFT_TWIDDLE_CONJ_EN
    in_inverse = 1'b0;
`endif
    for (int i = 0; i < 64; i++) rom[i] = {rnd16(), rnd16()};
    rom[0]  = 32'h7FFF_0000;
    rom[1]  = 32'h8000_8000;
    rom[2]  = 32'h7FFF_7FFF;
    rom[8]  = 32'h5A82_A57E;
    rom[16] = 32'h0000_8001;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re",    32'(out_re),    32'd0);
    chk("rst_out_im",    32'(out_im),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_rom_clken", 32'(rom_clken), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    send(16'h4000, 16'h2000, 6'h00, 1'b0, 1'b1);
    send(16'h4000, 16'h0000, 6'h10, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 6'h08, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 6'h01, 1'b0, 1'b1);
    send(16'h7FFF, 16'h8000, 6'h02, 1'b0, 1'b1);
`ifdef BELFFT_TWIDDLE_CONJ_EN
    send(16'h4000, 16'h0000, 6'h10, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 6'h01, 1'b1, 1'b1);
`endif
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 64; i++) send(rnd16(), rnd16(), AW'(i), rnd_inv(), 1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clock);
      send(rnd16(), rnd16(), AW'($urandom_range(0, 63)), rnd_inv(), 1'b0);
    end
    drain();

    rdy_mode = 2;
    @(negedge clock);
    for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), AW'(i), 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #4;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_re",    32'(out_re),    32'd0);
    chk("midrst_out_im",    32'(out_im),    32'd0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #3;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(negedge clock);
    send(16'h4000, 16'h2000, 6'h00, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
